// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and drives the IF/ID register.
// Optional build macro IF_FETCH_CNT_EN adds a 32-bit fetch_count output of presented instructions.
//
// state   | meaning
// FETCH   | request outstanding at pc (imem_req=0 only in the first cycle after reset)
// STALL   | acked word parked in skid buffer, waiting for the IF/ID register to free up
// DISCARD | redirect arrived mid-request; finish the old handshake, drop its data
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        inst_valid
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALL   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;

  logic        ack_fire;
  logic        can_load;
  logic        load_en;
  logic [31:0] pc_next;

  // An ack only counts against a request we are actually driving.
  assign ack_fire = imem_ack & imem_req;
  assign can_load = ~freeze | ~inst_valid;
  assign pc_next  = pc + PC_STEP;
  assign load_en  = ~branch_taken &
                    (((state == FETCH) & ack_fire & can_load) | ((state == STALL) & can_load));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      skid_data   <= 32'h0;
      skid_pc     <= 32'h0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      pc_out      <= 32'h0;
      instruction <= 32'h0;
      inst_valid  <= 1'b0;
    end else if (branch_taken) begin
      pc         <= branch_addr;
      inst_valid <= 1'b0;
      imem_req   <= 1'b1;
      // A live request cannot be withdrawn, so it is completed in DISCARD.
      if (imem_req && !ack_fire) begin
        state <= DISCARD;
      end else begin
        state     <= FETCH;
        imem_addr <= branch_addr;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack_fire) begin
            pc <= pc_next;
            if (can_load) begin
              instruction <= imem_rdata;
              pc_out      <= pc_next;
              inst_valid  <= 1'b1;
              imem_addr   <= pc_next;
            end else begin
              skid_data <= imem_rdata;
              skid_pc   <= pc_next;
              imem_req  <= 1'b0;
              state     <= STALL;
            end
          end else begin
            if (!freeze) inst_valid <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        STALL: begin
          if (can_load) begin
            instruction <= skid_data;
            pc_out      <= skid_pc;
            inst_valid  <= 1'b1;
            imem_req    <= 1'b1;
            imem_addr   <= pc;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          if (!freeze) inst_valid <= 1'b0;
          if (ack_fire) begin
            imem_addr <= pc;
            state     <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h0;
    end else if (load_en) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table plus randomized traffic vs a queue-based model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        inst_valid;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .inst_valid   (inst_valid)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: a queue of words waiting to be presented, plus a drop flag for redirects.
  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } word_t;
  word_t       q[$];
  logic [31:0] m_pc, m_addr, m_pcout, m_instr, m_cnt;
  bit          m_req, m_valid, m_drop;

  task automatic model_step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                            input bit ak, input logic [31:0] rd);
    bit    fire;
    bit    have;
    word_t cand;
    if (r) begin
      m_pc = RESET_PC; m_addr = 32'h0; m_req = 0; m_drop = 0; q.delete();
      m_valid = 0; m_pcout = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
      return;
    end
    fire = ak && m_req;
    if (b) begin
      m_valid = 0;
      q.delete();
      if (m_req && !fire) m_drop = 1;
      else begin
        m_drop = 0;
        m_addr = ba;
      end
      m_req = 1;
      m_pc  = ba;
      return;
    end
    have = 0;
    if (q.size() > 0) begin
      cand = q.pop_front();
      have = 1;
    end
    if (fire) begin
      if (m_drop) m_drop = 0;
      else begin
        cand.w = rd;
        cand.a = m_addr + PC_STEP;
        m_pc   = m_pc + PC_STEP;
        have   = 1;
      end
    end
    if (have) begin
      if (!f || !m_valid) begin
        m_instr = cand.w; m_pcout = cand.a; m_valid = 1; m_cnt = m_cnt + 1;
      end else q.push_front(cand);
    end else if (!f) m_valid = 0;
    if (q.size() == 0) begin
      m_req = 1;
      if (!m_drop) m_addr = m_pc;
    end else m_req = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("req_vs_model",   {31'b0, imem_req},   {31'b0, m_req});
    chk("addr_vs_model",  imem_addr,           m_addr);
    chk("valid_vs_model", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("pcout_vs_model", pc_out,              m_pcout);
    chk("instr_vs_model", instruction,         m_instr);
`ifdef IF_FETCH_CNT_EN
    chk("count_vs_model", fetch_count,         m_cnt);
`endif
  endtask

  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                      input bit ak, input logic [31:0] rd);
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ack = ak; imem_rdata = rd;
    @(posedge clk);
    model_step(r, f, b, ba, ak, rd);
    #1;
    cyc++;
    chk_model();
  endtask

  typedef struct {
    bit          rst, frz, br;
    logic [31:0] ba;
    bit          ack;
    logic [31:0] rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t tbl[29];

  initial begin
    // rst frz br ba ack rd | req addr valid pc_out instruction
    tbl[0]  = '{1,0,0,32'h0,0,32'h0,           0,32'h0,0,32'h0,32'h0};
    tbl[1]  = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h0};
    tbl[2]  = '{0,0,0,32'h0,1,32'hA000_0000,   1,32'h4,1,32'h4,32'hA000_0000};
    tbl[3]  = '{0,0,0,32'h0,1,32'hA000_0004,   1,32'h8,1,32'h8,32'hA000_0004};
    tbl[4]  = '{0,0,0,32'h0,1,32'hA000_0008,   1,32'hC,1,32'hC,32'hA000_0008};
    tbl[5]  = '{0,1,0,32'h0,1,32'hA000_000C,   0,32'hC,1,32'hC,32'hA000_0008};
    tbl[6]  = '{0,1,0,32'h0,0,32'h0,           0,32'hC,1,32'hC,32'hA000_0008};
    tbl[7]  = '{0,0,0,32'h0,0,32'h0,           1,32'h10,1,32'h10,32'hA000_000C};
    tbl[8]  = '{0,0,0,32'h0,1,32'hA000_0010,   1,32'h14,1,32'h14,32'hA000_0010};
    tbl[9]  = '{0,0,1,32'h100,0,32'h0,         1,32'h14,0,32'h14,32'hA000_0010};
    tbl[10] = '{0,0,0,32'h0,0,32'h0,           1,32'h14,0,32'h14,32'hA000_0010};
    tbl[11] = '{0,0,0,32'h0,1,32'hDEAD_BEEF,   1,32'h100,0,32'h14,32'hA000_0010};
    tbl[12] = '{0,0,0,32'h0,1,32'hA000_0100,   1,32'h104,1,32'h104,32'hA000_0100};
    tbl[13] = '{0,1,0,32'h0,1,32'hA000_0104,   0,32'h104,1,32'h104,32'hA000_0100};
    tbl[14] = '{0,1,1,32'h200,0,32'h0,         1,32'h200,0,32'h104,32'hA000_0100};
    tbl[15] = '{0,0,0,32'h0,1,32'hA000_0200,   1,32'h204,1,32'h204,32'hA000_0200};
    tbl[16] = '{0,0,0,32'h0,0,32'h0,           1,32'h204,0,32'h204,32'hA000_0200};
    tbl[17] = '{1,0,0,32'h0,0,32'h0,           0,32'h0,0,32'h0,32'h0};
    tbl[18] = '{0,0,0,32'h0,1,32'hBAD0_BAD0,   1,32'h0,0,32'h0,32'h0};
    tbl[19] = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h0};
    tbl[20] = '{0,0,0,32'h0,1,32'hA000_0000,   1,32'h4,1,32'h4,32'hA000_0000};
    tbl[21] = '{0,0,1,32'hFFFF_FFFC,1,32'h5555_5555, 1,32'hFFFF_FFFC,0,32'h4,32'hA000_0000};
    tbl[22] = '{0,0,0,32'h0,1,32'h1234_5678,   1,32'h0,1,32'h0,32'h1234_5678};
    tbl[23] = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h1234_5678};
    tbl[24] = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h1234_5678};
    tbl[25] = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h1234_5678};
    tbl[26] = '{0,0,0,32'h0,0,32'h0,           1,32'h0,0,32'h0,32'h1234_5678};
    tbl[27] = '{0,0,0,32'h0,1,32'hA000_0000,   1,32'h4,1,32'h4,32'hA000_0000};
    tbl[28] = '{0,0,0,32'h0,0,32'h0,           1,32'h4,0,32'h4,32'hA000_0000};

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].rst, tbl[i].frz, tbl[i].br, tbl[i].ba, tbl[i].ack, tbl[i].rd);
      chk($sformatf("row%0d_req", i),   {31'b0, imem_req},   {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d_addr", i),  imem_addr,           tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("row%0d_pcout", i), pc_out,              tbl[i].e_pc);
      chk($sformatf("row%0d_instr", i), instruction,         tbl[i].e_ins);
    end
`ifdef IF_FETCH_CNT_EN
    chk("count_after_table", fetch_count, 32'd3);
`endif

    // Reset held with ack asserted throughout: no request, and the stray ack must not leak out.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 32'h0, 1, 32'hFFFF_0000);
      chk("held_rst_req", {31'b0, imem_req}, 32'h0);
    end
    step(0, 0, 0, 32'h0, 1, 32'hFFFF_0001);
    chk("post_rst_first_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_stray_ack", {31'b0, inst_valid}, 32'h0);

    // Randomized traffic: wait states, freezes, redirects, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bit          r, f, b, ak;
      logic [31:0] ba, rd;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 19) == 0);
      ba = $urandom() & 32'hFFFF_FFFC;
      ak = ($urandom_range(0, 1) == 1);
      rd = $urandom();
      step(r, f, b, ba, ak, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
